// File: rtl/rv32_ctrl_pkg.sv
// Shared control-transfer constants for the RV32IM decode-side redirect logic.
package rv32_ctrl_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_JALR = 3'b000;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {RUN, FLUSH} state_e;

endpackage

// File: rtl/id_redirect_unit_if.sv
// Fetch <-> ID redirect bundle. Optional counters present when REDIRECT_PERF_EN is defined.
interface id_redirect_unit_if #(
  parameter int unsigned AddrSize  = 32,
  parameter int unsigned Inst_Size = 32
);

  logic [Inst_Size-1:0] Inst;
  logic [AddrSize-1:0]  PC_Temp;
  logic [31:0]          rs1_val;
  logic [31:0]          rs2_val;

  logic [Inst_Size-1:0] ID_Inst;
  logic [AddrSize-1:0]  ID_PC;
  logic                 ID_Valid;
  logic [AddrSize-1:0]  Link_Addr;
  logic [AddrSize-1:0]  Added_PC_from_Branch;
  logic [AddrSize-1:0]  Added_PC_from_Jump;
  logic                 PC_Select;
  logic                 Jump_Sel;
`ifdef REDIRECT_PERF_EN
  logic [31:0]          Branch_Taken_Count;
  logic [31:0]          Jump_Count;
`endif

  // Fetch / register-read side
  modport master (
    output Inst, PC_Temp, rs1_val, rs2_val,
`ifdef REDIRECT_PERF_EN
    input  Branch_Taken_Count, Jump_Count,
`endif
    input  ID_Inst, ID_PC, ID_Valid, Link_Addr, Added_PC_from_Branch, Added_PC_from_Jump,
    input  PC_Select, Jump_Sel
  );

  // Redirect unit side
  modport slave (
    input  Inst, PC_Temp, rs1_val, rs2_val,
`ifdef REDIRECT_PERF_EN
    output Branch_Taken_Count, Jump_Count,
`endif
    output ID_Inst, ID_PC, ID_Valid, Link_Addr, Added_PC_from_Branch, Added_PC_from_Jump,
    output PC_Select, Jump_Sel
  );

endinterface

// File: rtl/branch_compare.sv
// Conditional-branch outcome from funct3 and the two source operands.
module branch_compare
  import rv32_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic        taken
);

  // Evaluate the comparison selected by funct3; 010/011 are never taken
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (rs1_val == rs2_val);
      F3_BNE:  taken = (rs1_val != rs2_val);
      F3_BLT:  taken = ($signed(rs1_val) <  $signed(rs2_val));
      F3_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: taken = (rs1_val <  rs2_val);
      F3_BGEU: taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_redirect_unit.sv
// IF/ID pipeline register plus JAL/JALR/branch resolution with a one-bubble squash.
// Build option: define REDIRECT_PERF_EN to add taken-branch and jump counters.
module id_redirect_unit
  import rv32_ctrl_pkg::*;
#(
  parameter int unsigned AddrSize  = 32,
  parameter int unsigned Inst_Size = 32
) (
  input  logic               clk,
  input  logic               reset,
  id_redirect_unit_if.slave  bus
);

  logic [Inst_Size-1:0] inst_q;
  logic [AddrSize-1:0]  pc_q;
  logic                 valid_q;
  state_e               state_q, state_d;

  logic                 pc_select;
  logic                 jump_sel;
  logic                 taken;

  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [AddrSize+1:0]  j_off;
  logic [AddrSize+1:0]  b_off;
  logic [31:0]          i_imm;
  logic [31:0]          jalr_byte;
  logic [31:0]          jalr_word;
  logic [AddrSize-1:0]  jal_target;
  logic [AddrSize-1:0]  jalr_target;
  logic [AddrSize-1:0]  branch_target;

  assign opcode = inst_q[6:0];
  assign funct3 = inst_q[14:12];

  // Byte offsets sign-extended to AddrSize+2 bits so dropping [1:0] yields a word offset
  assign j_off = {{(AddrSize-19){inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20],
                  inst_q[30:21], 1'b0};
  assign b_off = {{(AddrSize-11){inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25],
                  inst_q[11:8], 1'b0};
  assign i_imm = {{20{inst_q[31]}}, inst_q[31:20]};

  assign jal_target    = pc_q + j_off[AddrSize+1:2];
  assign branch_target = pc_q + b_off[AddrSize+1:2];
  // JALR works on the 32-bit byte address; bit0 clear and word conversion both fall out of >> 2
  assign jalr_byte     = bus.rs1_val + i_imm;
  assign jalr_word     = jalr_byte >> 2;
  assign jalr_target   = AddrSize'(jalr_word);

  branch_compare u_branch_compare (
    .funct3  (funct3),
    .rs1_val (bus.rs1_val),
    .rs2_val (bus.rs2_val),
    .taken   (taken)
  );

  // Redirect decode and next-state; only a valid instruction in RUN may redirect
  always_comb begin
    pc_select = 1'b0;
    jump_sel  = 1'b0;
    state_d   = state_q;
    if (reset && valid_q && (state_q == RUN)) begin
      case (opcode)
        OP_JAL: begin
          pc_select = 1'b1;
          jump_sel  = 1'b1;
        end
        OP_JALR: begin
          if (funct3 == F3_JALR) begin
            pc_select = 1'b1;
            jump_sel  = 1'b1;
          end
        end
        OP_BRANCH: pc_select = taken;
        default: ;
      endcase
    end
    case (state_q)
      RUN:     if (pc_select) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // IF/ID register; the instruction fetched in a redirect cycle is replaced by a bubble
  always_ff @(posedge clk) begin
    if (!reset) begin
      inst_q  <= Inst_Size'(NOP_INST);
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (pc_select) begin
      inst_q  <= Inst_Size'(NOP_INST);
      valid_q <= 1'b0;
    end else begin
      inst_q  <= bus.Inst;
      pc_q    <= bus.PC_Temp - AddrSize'(1);
      valid_q <= 1'b1;
    end
  end

`ifdef REDIRECT_PERF_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] jump_cnt_q;

  // Redirect event counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (!reset) begin
      branch_cnt_q <= '0;
      jump_cnt_q   <= '0;
    end else if (pc_select) begin
      if (jump_sel) jump_cnt_q   <= jump_cnt_q + 32'd1;
      else          branch_cnt_q <= branch_cnt_q + 32'd1;
    end
  end

  assign bus.Branch_Taken_Count = branch_cnt_q;
  assign bus.Jump_Count         = jump_cnt_q;
`endif

  assign bus.ID_Inst              = inst_q;
  assign bus.ID_PC                = pc_q;
  assign bus.ID_Valid             = valid_q;
  assign bus.Link_Addr            = pc_q + AddrSize'(1);
  assign bus.Added_PC_from_Branch = branch_target;
  assign bus.Added_PC_from_Jump   = (opcode == OP_JALR) ? jalr_target : jal_target;
  assign bus.PC_Select            = pc_select;
  assign bus.Jump_Sel             = jump_sel;

endmodule

// File: tb/tb_id_redirect_unit.sv
// Directed bench for id_redirect_unit; perf-counter checks compile in with REDIRECT_PERF_EN.
module tb_id_redirect_unit;
  import rv32_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  localparam logic [31:0] ADDI1 = 32'h0010_0093;  // addi x1, x0, 1
  localparam logic [31:0] ADDI2 = 32'h0020_0113;  // addi x2, x0, 2

  id_redirect_unit_if bus ();

  id_redirect_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.Inst = enc_j(21'd8, 5'd1);
    bus.PC_Temp = 32'd5;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++; if (bus.ID_Valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h want 0", bus.ID_Valid); end
      checks++; if (bus.ID_Inst !== NOP_INST) begin errors++; $display("FAIL rst_inst got %08h want %08h", bus.ID_Inst, NOP_INST); end
      checks++; if (bus.ID_PC !== 32'd0) begin errors++; $display("FAIL rst_pc got %0h want 0", bus.ID_PC); end
      checks++; if (bus.PC_Select !== 1'b0) begin errors++; $display("FAIL rst_sel got %0h want 0", bus.PC_Select); end
      checks++; if (bus.Jump_Sel !== 1'b0) begin errors++; $display("FAIL rst_jsel got %0h want 0", bus.Jump_Sel); end
    end
    reset = 1'b1;
    bus.Inst = ADDI1;
    bus.PC_Temp = 32'd1;
    #1;
    checks++; if (bus.ID_Valid !== 1'b0) begin errors++; $display("FAIL rel_valid got %0h want 0", bus.ID_Valid); end
  endtask

  task automatic test_straight();
    for (int i = 0; i < 3; i++) begin
      bus.Inst = ADDI1;
      bus.PC_Temp = 32'(i + 1);
      cycle();
      checks++; if (bus.ID_PC !== 32'(i)) begin errors++; $display("FAIL seq_pc%0d got %0h want %0h", i, bus.ID_PC, i); end
      checks++; if (bus.ID_Valid !== 1'b1) begin errors++; $display("FAIL seq_valid%0d got %0h want 1", i, bus.ID_Valid); end
      checks++; if (bus.ID_Inst !== ADDI1) begin errors++; $display("FAIL seq_inst%0d got %08h want %08h", i, bus.ID_Inst, ADDI1); end
      checks++; if (bus.PC_Select !== 1'b0) begin errors++; $display("FAIL seq_sel%0d got %0h want 0", i, bus.PC_Select); end
    end
  endtask

  task automatic test_beq();
    bus.Inst = enc_b(13'd16, 5'd2, 5'd1, F3_BEQ);
    bus.PC_Temp = 32'd9;
    cycle();
    bus.rs1_val = 32'd5;
    bus.rs2_val = 32'd5;
    bus.Inst = ADDI1;  // wrong-path fetch
    bus.PC_Temp = 32'd10;
    #1;
    checks++; if (bus.ID_PC !== 32'd8) begin errors++; $display("FAIL beq_pc got %0h want 8", bus.ID_PC); end
    checks++; if (bus.PC_Select !== 1'b1) begin errors++; $display("FAIL beq_sel got %0h want 1", bus.PC_Select); end
    checks++; if (bus.Jump_Sel !== 1'b0) begin errors++; $display("FAIL beq_jsel got %0h want 0", bus.Jump_Sel); end
    checks++; if (bus.Added_PC_from_Branch !== 32'd12) begin errors++; $display("FAIL beq_tgt got %0h want c", bus.Added_PC_from_Branch); end
    cycle();
    checks++; if (bus.ID_Valid !== 1'b0) begin errors++; $display("FAIL beq_sq_valid got %0h want 0", bus.ID_Valid); end
    checks++; if (bus.ID_Inst !== NOP_INST) begin errors++; $display("FAIL beq_sq_inst got %08h want %08h", bus.ID_Inst, NOP_INST); end
    checks++; if (bus.ID_PC !== 32'd8) begin errors++; $display("FAIL beq_sq_pc got %0h want 8", bus.ID_PC); end
    checks++; if (dut.state_q !== FLUSH) begin errors++; $display("FAIL beq_state got %0h want FLUSH", dut.state_q); end
    checks++; if (bus.PC_Select !== 1'b0) begin errors++; $display("FAIL beq_fl_sel got %0h want 0", bus.PC_Select); end
    bus.Inst = ADDI2;
    bus.PC_Temp = 32'd13;
    cycle();
    checks++; if (bus.ID_PC !== 32'd12) begin errors++; $display("FAIL beq_tgt_pc got %0h want c", bus.ID_PC); end
    checks++; if (bus.ID_Inst !== ADDI2) begin errors++; $display("FAIL beq_tgt_inst got %08h want %08h", bus.ID_Inst, ADDI2); end
    checks++; if (bus.ID_Valid !== 1'b1) begin errors++; $display("FAIL beq_tgt_valid got %0h want 1", bus.ID_Valid); end
    checks++; if (dut.state_q !== RUN) begin errors++; $display("FAIL beq_run got %0h want RUN", dut.state_q); end
  endtask

  task automatic test_blt();
    bus.Inst = enc_b(13'd8, 5'd2, 5'd1, F3_BLT);
    bus.PC_Temp = 32'd13;
    cycle();
    bus.rs1_val = 32'hFFFF_FFFF;
    bus.rs2_val = 32'd1;
    bus.Inst = ADDI1;
    bus.PC_Temp = 32'd14;
    #1;
    checks++; if (bus.PC_Select !== 1'b1) begin errors++; $display("FAIL blt_sel got %0h want 1", bus.PC_Select); end
    checks++; if (bus.Jump_Sel !== 1'b0) begin errors++; $display("FAIL blt_jsel got %0h want 0", bus.Jump_Sel); end
    checks++; if (bus.Added_PC_from_Branch !== 32'd14) begin errors++; $display("FAIL blt_tgt got %0h want e", bus.Added_PC_from_Branch); end
    cycle();
    checks++; if (bus.ID_Valid !== 1'b0) begin errors++; $display("FAIL blt_sq got %0h want 0", bus.ID_Valid); end
`ifdef REDIRECT_PERF_EN
    checks++; if (bus.Branch_Taken_Count !== 32'd2) begin errors++; $display("FAIL blt_bcnt got %0d want 2", bus.Branch_Taken_Count); end
`endif
    bus.Inst = enc_b(13'd8, 5'd2, 5'd1, F3_BLTU);
    bus.PC_Temp = 32'd15;
    cycle();
    checks++; if (bus.PC_Select !== 1'b0) begin errors++; $display("FAIL bltu_sel got %0h want 0", bus.PC_Select); end
    checks++; if (bus.Jump_Sel !== 1'b0) begin errors++; $display("FAIL bltu_jsel got %0h want 0", bus.Jump_Sel); end
    checks++; if (bus.Added_PC_from_Branch !== 32'd16) begin errors++; $display("FAIL bltu_tgt got %0h want 10", bus.Added_PC_from_Branch); end
    checks++; if (bus.ID_PC !== 32'd14) begin errors++; $display("FAIL bltu_pc got %0h want e", bus.ID_PC); end
    bus.Inst = ADDI1;
    bus.PC_Temp = 32'd16;
    cycle();
    checks++; if (bus.ID_Valid !== 1'b1) begin errors++; $display("FAIL bltu_nobub got %0h want 1", bus.ID_Valid); end
    checks++; if (bus.ID_PC !== 32'd15) begin errors++; $display("FAIL bltu_next_pc got %0h want f", bus.ID_PC); end
    checks++; if (dut.state_q !== RUN) begin errors++; $display("FAIL bltu_state got %0h want RUN", dut.state_q); end
    bus.Inst = enc_b(13'd8, 5'd2, 5'd1, 3'b010);
    bus.PC_Temp = 32'd17;
    cycle();
    bus.rs1_val = 32'd5;
    bus.rs2_val = 32'd5;
    #1;
    checks++; if (bus.PC_Select !== 1'b0) begin errors++; $display("FAIL f3_010_sel got %0h want 0", bus.PC_Select); end
  endtask

  task automatic test_jalr();
    bus.Inst = enc_i(12'd2, 5'd3, F3_JALR, 5'd1, OP_JALR);
    bus.PC_Temp = 32'd5;
    cycle();
    bus.rs1_val = 32'h103;
    bus.Inst = ADDI1;
    bus.PC_Temp = 32'd6;
    #1;
    checks++; if (bus.Added_PC_from_Jump !== 32'h41) begin errors++; $display("FAIL jalr_tgt got %0h want 41", bus.Added_PC_from_Jump); end
    checks++; if (bus.Jump_Sel !== 1'b1) begin errors++; $display("FAIL jalr_jsel got %0h want 1", bus.Jump_Sel); end
    checks++; if (bus.PC_Select !== 1'b1) begin errors++; $display("FAIL jalr_sel got %0h want 1", bus.PC_Select); end
    checks++; if (bus.Link_Addr !== 32'd5) begin errors++; $display("FAIL jalr_link got %0h want 5", bus.Link_Addr); end
    cycle();
    checks++; if (dut.state_q !== FLUSH) begin errors++; $display("FAIL jalr_state got %0h want FLUSH", dut.state_q); end
    // reset while in FLUSH
    reset = 1'b0;
    cycle();
    checks++; if (dut.state_q !== RUN) begin errors++; $display("FAIL rstfl_state got %0h want RUN", dut.state_q); end
    checks++; if (bus.ID_Valid !== 1'b0) begin errors++; $display("FAIL rstfl_valid got %0h want 0", bus.ID_Valid); end
    checks++; if (bus.ID_PC !== 32'd0) begin errors++; $display("FAIL rstfl_pc got %0h want 0", bus.ID_PC); end
    reset = 1'b1;
  endtask

  task automatic test_jal();
    bus.Inst = enc_j(21'h1F_FFF8, 5'd1);  // imm = -8
    bus.PC_Temp = 32'd1;
    cycle();
    bus.Inst = ADDI1;
    bus.PC_Temp = 32'd2;
    #1;
    checks++; if (bus.ID_PC !== 32'd0) begin errors++; $display("FAIL jal_pc got %0h want 0", bus.ID_PC); end
    checks++; if (bus.Added_PC_from_Jump !== 32'hFFFF_FFFE) begin errors++; $display("FAIL jal_tgt got %0h want fffffffe", bus.Added_PC_from_Jump); end
    checks++; if (bus.PC_Select !== 1'b1) begin errors++; $display("FAIL jal_sel got %0h want 1", bus.PC_Select); end
    checks++; if (bus.Jump_Sel !== 1'b1) begin errors++; $display("FAIL jal_jsel got %0h want 1", bus.Jump_Sel); end
    checks++; if (bus.Link_Addr !== 32'd1) begin errors++; $display("FAIL jal_link got %0h want 1", bus.Link_Addr); end
`ifdef REDIRECT_PERF_EN
    checks++; if (bus.Jump_Count !== 32'd0) begin errors++; $display("FAIL jal_jcnt0 got %0d want 0", bus.Jump_Count); end
`endif
    cycle();
    checks++; if (bus.ID_Valid !== 1'b0) begin errors++; $display("FAIL jal_sq got %0h want 0", bus.ID_Valid); end
`ifdef REDIRECT_PERF_EN
    checks++; if (bus.Jump_Count !== 32'd1) begin errors++; $display("FAIL jal_jcnt1 got %0d want 1", bus.Jump_Count); end
    checks++; if (bus.Branch_Taken_Count !== 32'd0) begin errors++; $display("FAIL jal_bcnt got %0d want 0", bus.Branch_Taken_Count); end
`endif
  endtask

  // JAL sitting at the redirect target resolves in the first RUN cycle after FLUSH
  task automatic test_back_to_back();
    bus.Inst = enc_j(21'd16, 5'd1);
    bus.PC_Temp = 32'hFFFF_FFFF;
    cycle();
    #1;
    checks++; if (bus.ID_PC !== 32'hFFFF_FFFE) begin errors++; $display("FAIL b2b_pc got %0h want fffffffe", bus.ID_PC); end
    checks++; if (bus.PC_Select !== 1'b1) begin errors++; $display("FAIL b2b_sel got %0h want 1", bus.PC_Select); end
    checks++; if (bus.Added_PC_from_Jump !== 32'd2) begin errors++; $display("FAIL b2b_tgt got %0h want 2", bus.Added_PC_from_Jump); end
    checks++; if (bus.Link_Addr !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_link got %0h want ffffffff", bus.Link_Addr); end
    cycle();
`ifdef REDIRECT_PERF_EN
    checks++; if (bus.Jump_Count !== 32'd2) begin errors++; $display("FAIL b2b_jcnt got %0d want 2", bus.Jump_Count); end
`endif
    checks++; if (dut.state_q !== FLUSH) begin errors++; $display("FAIL b2b_state got %0h want FLUSH", dut.state_q); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.Inst = '0;
    bus.PC_Temp = '0;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    test_reset();
    test_straight();
    test_beq();
    test_blt();
    test_jalr();
    test_jal();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
